// File: rtl/point_extract_pkg.sv
// point_extract_pkg: image geometry defaults, FSM encodings and the edge test shared by the extractor.
package point_extract_pkg;
  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int IMG_XW     = $clog2(IMG_WIDTH);
  localparam int IMG_YW     = $clog2(IMG_HEIGHT);
  localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_DROP       = 2'd2;
  function automatic logic is_edge(input logic [7:0] pix, input logic [7:0] thr);
    return pix >= thr;
  endfunction
endpackage

// File: rtl/point_fifo.sv
// point_fifo: first-word fall-through FIFO; head entry is driven straight from storage.
module point_fifo #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic push_ok, pop_ok;
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = din;
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
    rd_d = rd_q + {{AW{1'b0}}, pop_ok};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/point_extract.sv
// point_extract: tracks raster (x,y), thresholds each pixel and queues edge coordinates for the Hough stage.
module point_extract
  import point_extract_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int XW     = IMG_XW,
  parameter int YW     = IMG_YW,
  parameter int DEPTH  = 16
) (
  input  logic          nReset,
  input  logic          Clk,
  input  logic [7:0]    Pixel,
  input  logic          Frame,
  input  logic          Line,
  input  logic [7:0]    Threshold,
  output logic [XW-1:0] PointX,
  output logic [YW-1:0] PointY,
  output logic          PointValid,
  input  logic          PointReady,
  output logic          FrameStart,
  output logic          Overflow,
  output logic          FmtErr
);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  logic [1:0] state_q, state_d;
  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic [7:0] thr_q, thr_d;
  logic frame_start_q, overflow_q, overflow_d, fmt_err_q, fmt_err_d;
  logic push, full, empty;
  logic [XW+YW-1:0] head;
  // Frame restarts the raster from any state; its own pixel uses the freshly sampled threshold.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    thr_d      = thr_q;
    fmt_err_d  = fmt_err_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    px         = x_q;
    py         = y_q;
    if (Frame) begin
      thr_d      = Threshold;
      push       = is_edge(Pixel, Threshold);
      px         = '0;
      py         = '0;
      x_d        = Line ? '0 : XW'(1);
      y_d        = Line ? YW'(1) : '0;
      state_d    = ST_RUN;
      fmt_err_d  = 1'b0;
      overflow_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      push       = is_edge(Pixel, thr_q);
      overflow_d = overflow_q | full;
      if (Line) begin
        x_d       = '0;
        y_d       = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        state_d   = (y_q == Y_LAST) ? ST_WAIT_FRAME : ST_RUN;
        fmt_err_d = fmt_err_q | (x_q != X_LAST);
      end else if (x_q == X_LAST) begin
        fmt_err_d = 1'b1;
        state_d   = ST_DROP;
      end else begin
        x_d = x_q + 1'b1;
      end
      overflow_d = overflow_q | (push && full);
    end
  end
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_WAIT_FRAME;
      x_q           <= '0;
      y_q           <= '0;
      thr_q         <= 8'hFF;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
      fmt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      thr_q         <= thr_d;
      frame_start_q <= Frame;
      overflow_q    <= overflow_d;
      fmt_err_q     <= fmt_err_d;
    end
  end
  point_fifo #(
    .DATA_W(XW + YW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (Clk),
    .rst_n(nReset),
    .push (push),
    .din  ({py, px}),
    .pop  (PointReady),
    .dout (head),
    .empty(empty),
    .full (full)
  );
  assign PointX     = head[XW-1:0];
  assign PointY     = head[XW+YW-1:XW];
  assign PointValid = !empty;
  assign FrameStart = frame_start_q;
  assign Overflow   = overflow_q;
  assign FmtErr     = fmt_err_q;
endmodule

// File: tb/tb_point_extract.sv
// tb_point_extract: directed raster scenarios checked every cycle against a queue-based model of the extractor.
module tb_point_extract;
  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 4;
  typedef logic [3:0] pt_t;
  logic Clk = 1'b0;
  logic nReset = 1'b1;
  logic [7:0] Pixel = '0;
  logic [7:0] Threshold = 8'd100;
  logic Frame = 1'b0;
  logic Line = 1'b0;
  logic PointReady = 1'b0;
  logic [2:0] PointX;
  logic [0:0] PointY;
  logic PointValid, FrameStart, Overflow, FmtErr;
  int tests = 0;
  int fails = 0;
  int fs_cnt = 0;
  bit chk_en = 0;
  pt_t mq[$];
  pt_t plog[$];
  int m_mode, m_x, m_y, m_thr;
  bit m_fs, m_ovf, m_fmt;

  point_extract #(.WIDTH(W), .HEIGHT(H), .XW(3), .YW(1), .DEPTH(D)) dut (
    .nReset(nReset), .Clk(Clk), .Pixel(Pixel), .Frame(Frame), .Line(Line),
    .Threshold(Threshold), .PointX(PointX), .PointY(PointY), .PointValid(PointValid),
    .PointReady(PointReady), .FrameStart(FrameStart), .Overflow(Overflow), .FmtErr(FmtErr)
  );

  always #5 Clk = ~Clk;

  function automatic pt_t mk(input int x, input int y);
    return pt_t'(y * 8 + x);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_x = 0; m_y = 0; m_thr = 255;
    m_fs = 0; m_ovf = 0; m_fmt = 0;
  endtask

  // mode 0 = waiting for a frame, 1 = scanning, 2 = discarding until the next frame
  task automatic model_update();
    int pre;
    bit pop, push, drop;
    int cx, cy;
    pre = mq.size();
    pop = PointReady && pre > 0;
    push = 0; cx = 0; cy = 0;
    if (Frame) begin
      m_thr = Threshold;
      push = Pixel >= Threshold;
      m_ovf = 0; m_fmt = 0; m_mode = 1;
      m_x = Line ? 0 : 1;
      m_y = Line ? 1 : 0;
    end else if (m_mode == 1) begin
      push = Pixel >= m_thr;
      cx = m_x; cy = m_y;
      if (Line) begin
        if (m_x < W - 1) m_fmt = 1;
        m_x = 0;
        if (m_y == H - 1) begin m_mode = 0; m_y = 0; end
        else m_y++;
      end else if (m_x == W - 1) begin
        m_fmt = 1; m_mode = 2;
      end else m_x++;
    end
    drop = push && pre == D;
    if (drop && !Frame) m_ovf = 1;
    if (pop) plog.push_back(mq.pop_front());
    if (push && !drop) mq.push_back(mk(cx, cy));
    m_fs = Frame;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      tests++;
      if (FrameStart) fs_cnt++;
      if (PointValid !== (mq.size() > 0) || (mq.size() > 0 && {PointY, PointX} !== mq[0]) ||
          FrameStart !== m_fs || Overflow !== m_ovf || FmtErr !== m_fmt) begin
        fails++;
        $display("FAIL cycle_check t=%0t: dut v=%0b x=%0d y=%0d fs=%0b ovf=%0b fmt=%0b; model v=%0b head=%0h fs=%0b ovf=%0b fmt=%0b",
                 $time, PointValid, PointX, PointY, FrameStart, Overflow, FmtErr,
                 mq.size() > 0, mq.size() > 0 ? mq[0] : 4'h0, m_fs, m_ovf, m_fmt);
      end
    end
  end

  task automatic step(input logic [7:0] p, input logic f, input logic l, input logic r);
    Pixel = p; Frame = f; Line = l; PointReady = r;
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    Pixel = '0; Frame = 0; Line = 0; PointReady = 0;
    nReset = 0;
    model_reset();
    @(posedge Clk);
    #1;
    nReset = 1;
  endtask

  initial begin
    #2;
    do_reset();
    chk_en = 1;
    chk("rst_valid", PointValid, 0);
    chk("rst_x", PointX, 0);
    chk("rst_y", PointY, 0);
    chk("rst_fs", FrameStart, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_fmt", FmtErr, 0);
    // basic line: edges at x=1 (equal to threshold) and x=3
    fs_cnt = 0;
    plog.delete();
    step(8'd0, 1, 0, 1);
    chk("s1_fs_pulse", FrameStart, 1);
    step(8'd100, 0, 0, 1);
    step(8'd99, 0, 0, 1);
    step(8'd255, 0, 0, 1);
    for (int i = 4; i < 8; i++) step(8'd0, 0, i == 7, 1);
    for (int i = 0; i < 8; i++) step(8'd0, 0, i == 7, 1);
    repeat (3) step(8'd255, 0, 0, 1);
    chk("s1_npops", plog.size(), 2);
    chk("s1_p0", plog[0], 4'h1);
    chk("s1_p1", plog[1], 4'h3);
    chk("s1_fs_count", fs_cnt, 1);
    // pixels before the first frame are ignored
    do_reset();
    repeat (5) step(8'd255, 0, 0, 1);
    chk("s2_idle_valid", PointValid, 0);
    step(8'd255, 1, 0, 0);
    chk("s2_valid", PointValid, 1);
    chk("s2_x", PointX, 0);
    chk("s2_y", PointY, 0);
    // overflow with the consumer stalled
    do_reset();
    plog.delete();
    step(8'd0, 1, 0, 0);
    for (int i = 1; i < 7; i++) step(8'd255, 0, 0, 0);
    step(8'd0, 0, 1, 0);
    chk("s3_ovf", Overflow, 1);
    chk("s3_valid", PointValid, 1);
    chk("s3_head", PointX, 1);
    for (int i = 0; i < 8; i++) step(8'd0, 0, i == 7, 1);
    chk("s3_npops", plog.size(), 4);
    for (int i = 0; i < 4; i++) chk("s3_pop", plog[i], i + 1);
    chk("s3_ovf_sticky", Overflow, 1);
    chk("s3_drained", PointValid, 0);
    step(8'd0, 1, 0, 1);
    chk("s3_ovf_clr", Overflow, 0);
    // missing Line at the last column
    do_reset();
    step(8'd0, 1, 0, 1);
    for (int i = 1; i < 8; i++) step(8'd0, 0, 0, 1);
    repeat (4) step(8'd255, 0, 0, 1);
    chk("s4_fmt", FmtErr, 1);
    chk("s4_dropped", PointValid, 0);
    step(8'd255, 1, 0, 1);
    chk("s4_fmt_clr", FmtErr, 0);
    chk("s4_valid", PointValid, 1);
    chk("s4_x", PointX, 0);
    chk("s4_y", PointY, 0);
    // full FIFO with simultaneous pop, then push+pop at count 2
    do_reset();
    plog.delete();
    step(8'd255, 1, 0, 0);
    for (int i = 1; i < 4; i++) step(8'd255, 0, 0, 0);
    step(8'd255, 0, 0, 1);
    chk("s5_ovf", Overflow, 1);
    chk("s5_head_after_drop", PointX, 1);
    step(8'd0, 0, 0, 1);
    step(8'd255, 0, 0, 1);
    chk("s5_head_pushpop", PointX, 3);
    step(8'd0, 0, 1, 1);
    chk("s5_head_new", PointX, 6);
    step(8'd0, 0, 0, 1);
    chk("s5_empty", PointValid, 0);
    chk("s5_npops", plog.size(), 5);
    chk("s5_p0", plog[0], 4'h0);
    chk("s5_p3", plog[3], 4'h3);
    chk("s5_p4", plog[4], 4'h6);
    // asynchronous reset with entries queued
    do_reset();
    step(8'd255, 1, 0, 0);
    step(8'd255, 0, 0, 0);
    step(8'd255, 0, 0, 0);
    chk("s6_queued", PointValid, 1);
    nReset = 0;
    model_reset();
    #1;
    chk("s6_async_valid", PointValid, 0);
    @(posedge Clk);
    #1;
    nReset = 1;
    repeat (4) step(8'd255, 0, 0, 1);
    chk("s6_ignored", PointValid, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
